// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: drives one active-low column at a time, debounces whole-frame
// scan results and keeps a 4-deep history of accepted key codes for a 4-digit display.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clock,
    input  logic       reset_i,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_down_o,
    output logic [3:0] data_dig_0,
    output logic [3:0] data_dig_1,
    output logic [3:0] data_dig_2,
    output logic [3:0] data_dig_3
);

    localparam int            PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    DB   = 3'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t        state;
    logic [3:0]    rows_meta, rows_sync;
    logic [PW-1:0] presc;
    logic [1:0]    col_idx;
    logic          acc_hit;
    logic [3:0]    acc_code;
    logic [3:0]    cand;
    logic [2:0]    cnt;

    logic          tick;
    logic          col_hit, hit;
    logic [3:0]    col_code, code;
    logic [2:0]    cnt_inc;

    // Rows idle high through the pull-ups, so the synchronizer resets to "no key".
    always_ff @(posedge i_clock or posedge reset_i) begin
        if (reset_i) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rows_i;
            rows_sync <= rows_meta;
        end
    end

    // hit/code are the frame result including the column sampled on this tick;
    // column 0 starts a fresh frame, so the accumulator is ignored there.
    always_comb begin
        tick     = (presc == PMAX);
        col_hit  = (rows_sync != 4'hF);
        col_code = '0;
        for (int r = 3; r >= 0; r--)
            if (!rows_sync[r]) col_code = {2'(r), col_idx};
        if (col_idx == 2'd0 || !acc_hit) begin
            hit  = col_hit;
            code = col_code;
        end else begin
            hit  = 1'b1;
            code = (col_hit && col_code < acc_code) ? col_code : acc_code;
        end
        cnt_inc = (cnt == 3'd7) ? cnt : cnt + 3'd1;
    end

    always_ff @(posedge i_clock or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            presc       <= '0;
            col_idx     <= 2'd0;
            cols_o      <= 4'b1110;
            acc_hit     <= 1'b0;
            acc_code    <= '0;
            cand        <= '0;
            cnt         <= '0;
            key_code_o  <= '0;
            key_valid_o <= 1'b0;
            key_down_o  <= 1'b0;
            data_dig_0  <= '0;
            data_dig_1  <= '0;
            data_dig_2  <= '0;
            data_dig_3  <= '0;
        end else begin
            key_valid_o <= 1'b0;
            presc       <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                col_idx  <= col_idx + 2'd1;
                cols_o   <= {cols_o[2:0], cols_o[3]};
                acc_hit  <= hit;
                acc_code <= code;
                if (col_idx == 2'd3) begin
                    unique case (state)
                        IDLE: begin
                            if (hit) begin
                                cand  <= code;
                                cnt   <= 3'd1;
                                state <= PRESS_CHK;
                            end
                        end
                        PRESS_CHK: begin
                            if (hit && code == cand) begin
                                cnt <= cnt_inc;
                                if (cnt_inc >= DB) begin
                                    state       <= HELD;
                                    key_down_o  <= 1'b1;
                                    key_valid_o <= 1'b1;
                                    key_code_o  <= cand;
                                    data_dig_3  <= data_dig_2;
                                    data_dig_2  <= data_dig_1;
                                    data_dig_1  <= data_dig_0;
                                    data_dig_0  <= cand;
                                end
                            end else begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end
                        HELD: begin
                            if (!hit) begin
                                cnt   <= 3'd1;
                                state <= RELEASE_CHK;
                            end
                        end
                        RELEASE_CHK: begin
                            if (!hit) begin
                                cnt <= cnt_inc;
                                if (cnt_inc >= DB) begin
                                    state      <= IDLE;
                                    key_down_o <= 1'b0;
                                end
                            end else begin
                                state <= HELD;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model driven from cols_o,
// expected key codes queued by the stimulus and checked by a pulse monitor.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [3:0] dig0, dig1, dig2, dig3;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .i_clock    (clk),
        .reset_i    (rst),
        .rows_i     (rows),
        .cols_o     (cols),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_down_o (key_down),
        .data_dig_0 (dig0),
        .data_dig_1 (dig1),
        .data_dig_2 (dig2),
        .data_dig_3 (dig3)
    );

    always #5 clk = ~clk;

    // Key k sits at row k[3:2], column k[1:0]; a pressed key pulls its row low
    // while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !cols[k % 4]) rows[k / 4] = 1'b0;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_digs(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        check("dig3", dig3, d3);
        check("dig2", dig2, d2);
        check("dig1", dig1, d1);
        check("dig0", dig0, d0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold key k for 6 frames, then release it and follow key_down through release.
    task automatic press_release(input logic [3:0] k);
        exp_q.push_back(k);
        keys[k] = 1'b1;
        wait_cycles(96);
        check("held_key_down", key_down, 1'b1);
        check("held_key_code", key_code, k);
        keys = '0;
        wait_cycles(16);
        check("release_chk_key_down", key_down, 1'b1);
        wait_cycles(80);
        check("released_key_down", key_down, 1'b0);
        check("queue_drained", 4'(exp_q.size()), 4'd0);
    endtask

    // Scoreboard monitor: every pulse must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (!rst && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got code %h expected no pulse", key_code);
            end else begin
                e = exp_q.pop_front();
                check("pulse_code", key_code, e);
                check("pulse_dig0", dig0, e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0] exp_col;
        bit         all_low, all_high;
        keys = '0;
        rst  = 1'b1;
        wait_cycles(3);

        // 1. reset state and column ring
        check("rst_cols", cols, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_down", key_down, 1'b0);
        check_digs(4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check("col_ring", cols, exp_col);
            @(negedge clk);
        end

        // 2. single key row2/col1
        press_release(4'h9);
        check("t2_code", key_code, 4'h9);
        check_digs(4'h0, 4'h0, 4'h0, 4'h9);

        // 3. bounce shorter than the debounce window
        keys[6] = 1'b1;
        all_low = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (key_down !== 1'b0) all_low = 1'b0;
            @(negedge clk);
        end
        keys = '0;
        for (int i = 0; i < 96; i++) begin
            if (key_down !== 1'b0) all_low = 1'b0;
            @(negedge clk);
        end
        check("t3_never_down", {3'b0, all_low}, 4'h1);
        check("t3_code", key_code, 4'h9);
        check_digs(4'h0, 4'h0, 4'h0, 4'h9);

        // 4. history shift
        press_release(4'h1);
        press_release(4'h2);
        press_release(4'h3);
        press_release(4'h4);
        check_digs(4'h1, 4'h2, 4'h3, 4'h4);
        press_release(4'hF);
        check_digs(4'h2, 4'h3, 4'h4, 4'hF);

        // 5. two keys resolve to the lower code; a key added while held is ignored
        exp_q.push_back(4'h3);
        keys[3] = 1'b1;
        keys[4] = 1'b1;
        wait_cycles(96);
        check("t5_code", key_code, 4'h3);
        check("t5_down", key_down, 1'b1);
        keys[10] = 1'b1;
        wait_cycles(96);
        check("t5_code_after_add", key_code, 4'h3);
        check("t5_down_after_add", key_down, 1'b1);
        keys = '0;
        wait_cycles(96);
        check("t5_released", key_down, 1'b0);
        check("t5_queue", 4'(exp_q.size()), 4'd0);
        check_digs(4'h3, 4'h4, 4'hF, 4'h3);

        // 6. single no-hit frame while held does not retrigger
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        wait_cycles(96);
        all_high = 1'b1;
        keys = '0;
        for (int i = 0; i < 16; i++) begin
            if (key_down !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        keys[5] = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (key_down !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        check("t6_stays_down", {3'b0, all_high}, 4'h1);
        keys = '0;
        wait_cycles(96);
        check("t6_released", key_down, 1'b0);
        check("t6_queue", 4'(exp_q.size()), 4'd0);
        check_digs(4'h4, 4'hF, 4'h3, 4'h5);

        // 6b. asynchronous reset in the middle of press debounce
        keys[6] = 1'b1;
        wait_cycles(32);
        #2 rst = 1'b1;
        #1;
        check("arst_cols", cols, 4'b1110);
        check("arst_code", key_code, 4'h0);
        check("arst_down", key_down, 1'b0);
        check("arst_valid", key_valid, 1'b0);
        check_digs(4'h0, 4'h0, 4'h0, 4'h0);
        keys = '0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(96);
        check("post_rst_down", key_down, 1'b0);
        check("post_rst_code", key_code, 4'h0);
        check_digs(4'h0, 4'h0, 4'h0, 4'h0);
        check("post_rst_queue", 4'(exp_q.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
